// File: rtl/key_debounce.sv
// Multi-channel active-low push-button debouncer: 2-flop synchroniser, per-key
// confirm FSM, registered press/release strobes. Optional long-press detection via KEY_DEBOUNCE_LONG_EN.
module key_debounce #(
  parameter int unsigned NKEYS       = 2,
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_long
);

  localparam int unsigned DB_CYCLES   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned LONG_CYCLES = (CLK_HZ / 1000) * LONG_MS;
  localparam int unsigned MAX_CYCLES  = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
  localparam int unsigned CW          = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
`ifdef KEY_DEBOUNCE_LONG_EN
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM_PRESS,
    S_PRESSED,
    S_CONFIRM_RELEASE
  } state_t;

  logic [NKEYS-1:0] sync_q1;
  logic [NKEYS-1:0] sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] rcnt, rcnt_nx;
    logic          level_q, level_nx;
    logic          press_q, press_nx;
    logic          release_q, release_nx;
    logic          s;
`ifdef KEY_DEBOUNCE_LONG_EN
    logic          long_q, long_nx;
`endif

    assign s = sync_q2[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= S_IDLE;
        cnt       <= '0;
        rcnt      <= '0;
        level_q   <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_DEBOUNCE_LONG_EN
        long_q    <= 1'b0;
`endif
      end else begin
        state     <= state_nx;
        cnt       <= cnt_nx;
        rcnt      <= rcnt_nx;
        level_q   <= level_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
`ifdef KEY_DEBOUNCE_LONG_EN
        long_q    <= long_nx;
`endif
      end
    end

    always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      rcnt_nx    = rcnt;
      level_nx   = level_q;
      press_nx   = 1'b0;
      release_nx = 1'b0;
`ifdef KEY_DEBOUNCE_LONG_EN
      long_nx    = 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (!s) begin
            state_nx = S_CONFIRM_PRESS;
            cnt_nx   = CW'(1);
          end
        end
        S_CONFIRM_PRESS: begin
          if (s) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else if (cnt == DB_LAST) begin
            state_nx = S_PRESSED;
            level_nx = 1'b0;
            press_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          if (s) begin
            state_nx = S_CONFIRM_RELEASE;
            rcnt_nx  = CW'(1);
          end
`ifdef KEY_DEBOUNCE_LONG_EN
          // Saturating hold counter; the strobe fires only on the edge it reaches the limit.
          else if (cnt != LONG_MAX) begin
            cnt_nx  = cnt + 1'b1;
            long_nx = (cnt == LONG_LAST);
          end
`endif
        end
        S_CONFIRM_RELEASE: begin
          // Bounce back to PRESSED keeps cnt so the hold time is not restarted.
          if (!s) begin
            state_nx = S_PRESSED;
            rcnt_nx  = '0;
          end else if (rcnt == DB_LAST) begin
            state_nx   = S_IDLE;
            level_nx   = 1'b1;
            release_nx = 1'b1;
            cnt_nx     = '0;
            rcnt_nx    = '0;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
`ifdef KEY_DEBOUNCE_LONG_EN
    assign key_long[i]    = long_q;
`endif
  end

`ifndef KEY_DEBOUNCE_LONG_EN
  assign key_long = '0;
`endif

endmodule
